// File: rtl/collision_scan_controller.sv
// Per-frame dragon collision scheduler: snapshots entity/segment positions, scans one segment per cycle.
// Optional SHEEP_CHECK_EN enables the sheep comparator; otherwise sheep_hit is tied to 0.
module collision_scan_controller #(
    parameter int unsigned SEGMENTS = 7,
    parameter int unsigned POS_W    = 8,
    parameter int unsigned IDX_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic [POS_W-1:0]          player_pos,
    input  logic [POS_W-1:0]          sword_pos,
    input  logic                      attack_enable,
    input  logic [POS_W-1:0]          sheep_pos,
    input  logic [SEGMENTS*POS_W-1:0] dragon_pos,
    input  logic [SEGMENTS-1:0]       dragon_active,
    output logic                      busy,
    output logic                      done,
    output logic                      player_hit,
    output logic                      sword_hit,
    output logic                      sheep_hit,
    output logic [IDX_W-1:0]          sword_hit_idx,
    output logic                      overrun
);

    typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

    localparam logic [IDX_W-1:0] IdxNone = '1;
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(SEGMENTS - 1);

    state_e state_q, state_d;

    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [POS_W-1:0]          player_q, player_d;
    logic [POS_W-1:0]          sword_q, sword_d;
    logic                      attack_q, attack_d;
    logic [SEGMENTS*POS_W-1:0] dragon_q, dragon_d;
    logic [SEGMENTS-1:0]       active_q, active_d;
    logic                      pend_q, pend_d;

    logic                      acc_p_q, acc_p_d;
    logic                      acc_s_q, acc_s_d;
    logic [IDX_W-1:0]          acc_idx_q, acc_idx_d;

    logic                      player_hit_q, player_hit_d;
    logic                      sword_hit_q, sword_hit_d;
    logic [IDX_W-1:0]          sword_idx_q, sword_idx_d;
    logic                      overrun_q, overrun_d;

    logic                      accept, last;
    logic [POS_W-1:0]          seg_pos;
    logic                      seg_act, sword_armed, p_hit, s_hit;
    logic                      nxt_p, nxt_s;
    logic [IDX_W-1:0]          nxt_idx;

`ifdef SHEEP_CHECK_EN
    logic [POS_W-1:0]          sheep_q, sheep_d;
    logic                      acc_sh_q, acc_sh_d;
    logic                      sheep_hit_q, sheep_hit_d;
    logic                      sh_hit, nxt_sh;
`else
    logic                      unused_sheep;
    assign unused_sheep = ^sheep_pos;
`endif

    assign accept = frame_start && (state_q != StScan);
    assign last   = (state_q == StScan) && (cnt_q == IdxLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StScan;
            StScan:   if (last) state_d = StReport;
            StReport: state_d = frame_start ? StScan : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StScan);
        done = (state_q == StReport);
    end

    always_comb begin
        seg_pos = '0;
        seg_act = 1'b0;
        for (int i = 0; i < int'(SEGMENTS); i++) begin
            if (cnt_q == IDX_W'(i)) begin
                seg_pos = dragon_q[i*POS_W +: POS_W];
                seg_act = active_q[i];
            end
        end
        sword_armed = attack_q && (sword_q != '0);
        p_hit       = seg_act && (seg_pos == player_q);
        s_hit       = seg_act && sword_armed && (seg_pos == sword_q);
`ifdef SHEEP_CHECK_EN
        sh_hit      = seg_act && (seg_pos == sheep_q);
`endif
    end

    always_comb begin
        cnt_d        = cnt_q;
        player_d     = player_q;
        sword_d      = sword_q;
        attack_d     = attack_q;
        dragon_d     = dragon_q;
        active_d     = active_q;
        pend_d       = pend_q;
        acc_p_d      = acc_p_q;
        acc_s_d      = acc_s_q;
        acc_idx_d    = acc_idx_q;
        player_hit_d = player_hit_q;
        sword_hit_d  = sword_hit_q;
        sword_idx_d  = sword_idx_q;
        overrun_d    = overrun_q;
        nxt_p        = acc_p_q | p_hit;
        nxt_s        = acc_s_q | s_hit;
        // Only the first armed hit records its index.
        nxt_idx      = (s_hit && !acc_s_q) ? cnt_q : acc_idx_q;
`ifdef SHEEP_CHECK_EN
        sheep_d      = sheep_q;
        acc_sh_d     = acc_sh_q;
        sheep_hit_d  = sheep_hit_q;
        nxt_sh       = acc_sh_q | sh_hit;
`endif

        if (accept) begin
            player_d  = player_pos;
            sword_d   = sword_pos;
            attack_d  = attack_enable;
            dragon_d  = dragon_pos;
            active_d  = dragon_active;
            cnt_d     = '0;
            pend_d    = 1'b0;
            acc_p_d   = 1'b0;
            acc_s_d   = 1'b0;
            acc_idx_d = IdxNone;
`ifdef SHEEP_CHECK_EN
            sheep_d   = sheep_pos;
            acc_sh_d  = 1'b0;
`endif
        end else if (state_q == StScan) begin
            if (frame_start) pend_d = 1'b1;
            cnt_d     = cnt_q + IDX_W'(1);
            acc_p_d   = nxt_p;
            acc_s_d   = nxt_s;
            acc_idx_d = nxt_idx;
`ifdef SHEEP_CHECK_EN
            acc_sh_d  = nxt_sh;
`endif
            if (last) begin
                player_hit_d = nxt_p;
                sword_hit_d  = nxt_s;
                sword_idx_d  = nxt_idx;
                overrun_d    = pend_q | frame_start;
                cnt_d        = '0;
                acc_p_d      = 1'b0;
                acc_s_d      = 1'b0;
                acc_idx_d    = IdxNone;
`ifdef SHEEP_CHECK_EN
                sheep_hit_d  = nxt_sh;
                acc_sh_d     = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            player_q     <= '0;
            sword_q      <= '0;
            attack_q     <= 1'b0;
            dragon_q     <= '0;
            active_q     <= '0;
            pend_q       <= 1'b0;
            acc_p_q      <= 1'b0;
            acc_s_q      <= 1'b0;
            acc_idx_q    <= IdxNone;
            player_hit_q <= 1'b0;
            sword_hit_q  <= 1'b0;
            sword_idx_q  <= IdxNone;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            player_q     <= player_d;
            sword_q      <= sword_d;
            attack_q     <= attack_d;
            dragon_q     <= dragon_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            acc_p_q      <= acc_p_d;
            acc_s_q      <= acc_s_d;
            acc_idx_q    <= acc_idx_d;
            player_hit_q <= player_hit_d;
            sword_hit_q  <= sword_hit_d;
            sword_idx_q  <= sword_idx_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SHEEP_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sheep_q     <= '0;
            acc_sh_q    <= 1'b0;
            sheep_hit_q <= 1'b0;
        end else begin
            sheep_q     <= sheep_d;
            acc_sh_q    <= acc_sh_d;
            sheep_hit_q <= sheep_hit_d;
        end
    end
    assign sheep_hit = sheep_hit_q;
`else
    assign sheep_hit = 1'b0;
`endif

    assign player_hit    = player_hit_q;
    assign sword_hit     = sword_hit_q;
    assign sword_hit_idx = sword_idx_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_collision_scan_controller.sv
// Self-checking bench for collision_scan_controller: vector table plus scoreboard of expected reports.
module tb_collision_scan_controller;

    localparam int SEG = 7;
    localparam int PW  = 8;
    localparam int IW  = 3;
`ifdef SHEEP_CHECK_EN
    localparam logic SheepEn = 1'b1;
`else
    localparam logic SheepEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0;
    logic [PW-1:0]     player_pos = '0;
    logic [PW-1:0]     sword_pos = '0;
    logic              attack_enable = 1'b0;
    logic [PW-1:0]     sheep_pos = '0;
    logic [SEG*PW-1:0] dragon_pos = '0;
    logic [SEG-1:0]    dragon_active = '0;
    logic              busy, done, player_hit, sword_hit, sheep_hit, overrun;
    logic [IW-1:0]     sword_hit_idx;

    collision_scan_controller #(.SEGMENTS(SEG), .POS_W(PW), .IDX_W(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .player_pos    (player_pos),
        .sword_pos     (sword_pos),
        .attack_enable (attack_enable),
        .sheep_pos     (sheep_pos),
        .dragon_pos    (dragon_pos),
        .dragon_active (dragon_active),
        .busy          (busy),
        .done          (done),
        .player_hit    (player_hit),
        .sword_hit     (sword_hit),
        .sheep_hit     (sheep_hit),
        .sword_hit_idx (sword_hit_idx),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]     player;
        logic [PW-1:0]     sword;
        logic              attack;
        logic [PW-1:0]     sheep;
        logic [SEG*PW-1:0] dragon;
        logic [SEG-1:0]    active;
        logic              e_p;
        logic              e_s;
        logic              e_sh;
        logic [IW-1:0]     e_idx;
    } vec_t;

    typedef struct {
        logic          p;
        logic          s;
        logic          sh;
        logic [IW-1:0] idx;
        logic          ovr;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done strobe consumes one expected report.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no report (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("player_hit", player_hit, mon_e.p);
                chk("sword_hit", sword_hit, mon_e.s);
                chk("sheep_hit", sheep_hit, mon_e.sh);
                chk("sword_hit_idx", sword_hit_idx, mon_e.idx);
                chk("overrun", overrun, mon_e.ovr);
            end
        end
    end

    task automatic drive(input vec_t v);
        player_pos    = v.player;
        sword_pos     = v.sword;
        attack_enable = v.attack;
        sheep_pos     = v.sheep;
        dragon_pos    = v.dragon;
        dragon_active = v.active;
    endtask

    task automatic push(input vec_t v, input logic ovr);
        exp_t e;
        e.p   = v.e_p;
        e.s   = v.e_s;
        e.sh  = v.e_sh & SheepEn;
        e.idx = v.e_idx;
        e.ovr = ovr;
        sb.push_back(e);
    endtask

    // Single-pulse scan with latency and busy-window checks.
    task automatic run_scan(input vec_t v);
        @(negedge clk);
        drive(v);
        frame_start = 1'b1;
        push(v, 1'b0);
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_e0", busy, 1);
        chk("done_e0", done, 0);
        for (int k = 1; k <= SEG; k++) begin
            @(negedge clk);
            if (k < SEG) begin
                chk("busy_scan", busy, 1);
                chk("done_early", done, 0);
            end else begin
                chk("done_latency", done, 1);
                chk("busy_report", busy, 0);
            end
        end
        @(negedge clk);
        chk("done_strobe_len", done, 0);
    endtask

    initial begin
        int dq[$];
        int dones;

        vecs[0] = '{8'h35, 8'h00, 1'b0, 8'h77, 56'hA6A5A4A335A1A0, 7'h7F, 1, 0, 0, 3'd7};
        vecs[1] = '{8'h11, 8'h42, 1'b0, 8'h77, 56'hA64242A3A2A1A0, 7'h7F, 0, 0, 0, 3'd7};
        vecs[2] = '{8'h11, 8'h42, 1'b1, 8'h77, 56'hA64242A3A2A1A0, 7'h7F, 0, 1, 0, 3'd4};
        vecs[3] = '{8'h11, 8'h00, 1'b1, 8'h77, 56'hA64242A3A200A0, 7'h7F, 0, 0, 0, 3'd7};
        vecs[4] = '{8'h11, 8'h00, 1'b0, 8'h10, 56'hA6A5A410A2A1A0, 7'h77, 0, 0, 0, 3'd7};
        vecs[5] = '{8'h11, 8'h00, 1'b0, 8'h10, 56'hA6A5A410A2A1A0, 7'h7F, 0, 0, 1, 3'd7};
        vecs[6] = '{8'h35, 8'h35, 1'b1, 8'h35, 56'hA6A5A4A3A2A135, 7'h00, 0, 0, 0, 3'd7};
        vecs[7] = '{8'h5A, 8'h5A, 1'b1, 8'h5A, 56'h5AA5A4A3A2A1A0, 7'h7F, 1, 1, 1, 3'd6};
        vecs[8] = '{8'h11, 8'h77, 1'b1, 8'h12, 56'h77A5A4A3A2A177, 7'h7F, 0, 1, 0, 3'd0};
        vecs[9] = '{8'h11, 8'h77, 1'b1, 8'h12, 56'h77A5A4A3A2A177, 7'h7E, 0, 1, 0, 3'd6};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_player_hit", player_hit, 0);
        chk("rst_sword_hit", sword_hit, 0);
        chk("rst_sheep_hit", sheep_hit, 0);
        chk("rst_idx", sword_hit_idx, 3'd7);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_scan(vecs[i]);

        // frame_start held for 20 edges: three back-to-back scans, each flagged as overrun.
        @(negedge clk);
        drive(vecs[0]);
        frame_start = 1'b1;
        for (int j = 0; j < 3; j++) push(vecs[0], 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 19) frame_start = 1'b0;
            if (done === 1'b1) dq.push_back(c);
        end
        chk("b2b_done_count", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("b2b_first_done", dq[0], 7);
            chk("b2b_period_1", dq[1] - dq[0], 8);
            chk("b2b_period_2", dq[2] - dq[1], 8);
        end
        run_scan(vecs[0]);

        // Input change after acceptance must not affect the running scan.
        @(negedge clk);
        drive('{8'h11, 8'h00, 1'b0, 8'h77, 56'hA6A5A4A3A2A166, 7'h7F, 0, 0, 0, 3'd7});
        frame_start = 1'b1;
        push('{8'h11, 8'h00, 1'b0, 8'h77, 56'hA6A5A4A3A2A166, 7'h7F, 0, 0, 0, 3'd7}, 1'b0);
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        player_pos    = 8'h66;
        sword_pos     = 8'h66;
        attack_enable = 1'b1;
        repeat (8) @(negedge clk);

        // Reset mid-scan: outputs clear at once and the aborted scan never reports.
        run_scan(vecs[7]);
        @(negedge clk);
        drive(vecs[7]);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_player_hit", player_hit, 0);
        chk("arst_sword_hit", sword_hit, 0);
        chk("arst_sheep_hit", sheep_hit, 0);
        chk("arst_idx", sword_hit_idx, 3'd7);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("no_done_after_reset", dones, 0);
        chk("idle_after_reset", busy, 0);
        run_scan(vecs[2]);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
